i2s_transmitter: RTL
====================

// Module: i2s_transmitter
// PURPOSE
//   I2S master transmitter, the playback counterpart of the microphone capture path.
//   Drains signed PCM words from a synchronous FIFO. The FIFO registers read data one clk after rd_en.
//   Generates BCLK and LRCLK and serialises each word MSB-first, in standard I2S format, to a DAC/codec.
//   FIFO words alternate left/right; the first word after start is left.
// PARAMETERS
//   DATA_WIDTH  24  bits per sample word; must satisfy DATA_WIDTH <= SLOT_WIDTH-1
//   SLOT_WIDTH  32  BCLK periods per channel slot (frame = 2*SLOT_WIDTH)
//   CLK_DIV     4   clk cycles per BCLK half-period; must be >= 2
// PORTS
//   clk           in   1           system clock, single clock domain
//   rst           in   1           synchronous reset, active-high
//   enable_i      in   1           level: 1 = stream, 0 = stop at end of current frame
//   fifo_rd_en_o  out  1           one-clk read strobe to FIFO, never asserted while fifo_empty_i=1
//   fifo_empty_i  in   1           FIFO empty flag
//   fifo_data_i   in   DATA_WIDTH  FIFO read data, valid the clk after fifo_rd_en_o
//   bclk_o        out  1           bit clock
//   lrclk_o       out  1           word select: 0 = left, 1 = right
//   sdata_o       out  1           serial data, changes only on BCLK falling edge
//   busy_o        out  1           1 in PRIME/RUN/DRAIN
//   underrun_o    out  1           sticky: a slot needed data while FIFO was empty
// BEHAVIOUR
//   Reset: all outputs 0. State = IDLE, divider = 0, b = 0, registers cleared.
//   Reset mid-operation aborts immediately. No further rd_en is issued.
//   FSM states: IDLE, PRIME, RUN, DRAIN.
//   IDLE: bclk, lrclk and sdata are held 0.
//     enable_i=1 -> PRIME. The same transition clears underrun_o.
//   PRIME: waits while fifo_empty_i=1; no underrun is flagged here.
//     When !empty, pulse rd_en for one clk. Capture fifo_data_i the next clk.
//     The following clk -> RUN, with b=0, lrclk=0, bclk=0, shift register loaded.
//   BCLK generation: divider counts 0..CLK_DIV-1 and toggles bclk at terminal count.
//     First rising edge occurs CLK_DIV clks after RUN entry. Period = 2*CLK_DIV clks.
//   On each BCLK falling edge, slot bit index b increments.
//     At SLOT_WIDTH-1 -> 0 it wraps: lrclk toggles and the shift register loads next_word.
//   sdata at slot position b:
//     b=0 -> 0 (one-bit I2S delay after the WS change).
//     b=1..DATA_WIDTH -> word[DATA_WIDTH-b], i.e. MSB first.
//     b > DATA_WIDTH -> 0 (padding).
//   Prefetch: on the falling edge entering b=SLOT_WIDTH-1, the block fetches the next word.
//     If !fifo_empty_i: pulse fifo_rd_en_o for one clk and capture data into next_word the next clk.
//     If empty: next_word=0, no rd_en, underrun_o<=1 (sticky).
//     The empty slot transmits zeros; alignment of the left/right pairing is preserved.
//   Stop: if enable_i=0 at a right->left wrap (frame boundary), the FSM takes RUN -> DRAIN.
//     Prefetch for a left slot is skipped whenever enable_i=0, so no word is consumed for a frame that is not sent.
//     DRAIN: bclk returns low, then -> IDLE after one clk.
//     enable_i dropping mid-frame still completes the right slot.
//   enable_i re-asserted during DRAIN is honoured on return to IDLE.
//   At most one rd_en per slot; rd_en never coincides with fifo_empty_i=1.
// STRUCTURE
//   Package i2s_pkg: i2s_tx_state_e {IDLE,PRIME,RUN,DRAIN}; channel enum {CH_LEFT=0,CH_RIGHT=1}.
//   Sub-module i2s_clk_gen (parameter CLK_DIV): enable in; bclk, rise and fall one-clk strobes out.
//   FSM, slot counter, shift register and prefetch logic stay in i2s_transmitter.
// TESTING (DATA_WIDTH=24, SLOT_WIDTH=32, CLK_DIV=4, FIFO model with 1-clk read latency)
//   1 Reset with enable=1 -> all outputs 0, no rd_en for 20 clks.
//     Release -> rd_en exactly once, RUN 2 clks later.
//   2 FIFO holds 0xA5A5A5, 0x5A5A5A; enable=1 ->
//     left slot: sdata bits 1..24 = A5A5A5 MSB-first, bit 0 and bits 25..31 = 0;
//     right slot = 5A5A5A; lrclk toggles on a falling edge every 32 BCLKs.
//   3 BCLK timing -> period 8 clks, 50% duty;
//     sdata/lrclk change only on clks where bclk falls.
//   4 FIFO empties after 3 words -> 4th slot (right) all zeros, underrun_o=1, no rd_en while empty.
//     Refill -> next left slot resumes with the correct word.
//   5 Drop enable mid-left slot -> right slot completes, then IDLE, busy_o=0.
//     No rd_en after the right-slot prefetch; the FIFO word count is unchanged.
//   6 Assert rst mid-word -> next clk all outputs 0.
//     Re-enable -> stream restarts on left with underrun_o cleared.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared state and channel types for the I2S transmitter
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN
    } i2s_tx_state_e;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_channel_e;

    function automatic i2s_channel_e other_channel(input i2s_channel_e ch);
        return (ch == CH_LEFT) ? CH_RIGHT : CH_LEFT;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - BCLK divider with rise/fall strobes
module i2s_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bclk,
    output logic rise,
    output logic fall
);
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIVW-1:0] TC = DIVW'(CLK_DIV - 1);

    logic [DIVW-1:0] div;
    logic            tc;

    // Strobes lead bclk by one clk so users update on the same edge bclk moves.
    assign tc   = enable && (div == TC);
    assign rise = tc && !bclk;
    assign fall = tc && bclk;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (tc) begin
            div  <= '0;
            bclk <= ~bclk;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S master transmitter draining a 1-clk-latency FIFO
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    output logic                  fifo_rd_en_o,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  bclk_o,
    output logic                  lrclk_o,
    output logic                  sdata_o,
    output logic                  busy_o,
    output logic                  underrun_o
);
    localparam int BW = $clog2(SLOT_WIDTH);
    localparam logic [BW-1:0] LAST_B = BW'(SLOT_WIDTH - 1);
    localparam logic [BW-1:0] PF_B   = BW'(SLOT_WIDTH - 2);
    localparam logic [BW-1:0] DATA_B = BW'(DATA_WIDTH);

    i2s_tx_state_e         state, state_next;
    i2s_channel_e          ch;
    logic [BW-1:0]         b;
    logic [DATA_WIDTH-1:0] shreg, next_word;
    logic                  sdata, underrun, prime_pend, cap_pend, armed;
    logic                  run_en, bclk, rise, fall;
    logic                  at_last, wrap, prime_rd, pf_rd, pf_miss;

    assign run_en = (state == RUN);

    i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (run_en),
        .bclk   (bclk),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        at_last    = (b == LAST_B);
        wrap       = run_en && fall && at_last;
        prime_rd   = (state == PRIME) && !prime_pend && !fifo_empty_i;
        pf_rd      = run_en && rise && at_last && armed && !fifo_empty_i;
        pf_miss    = run_en && rise && at_last && armed && fifo_empty_i;
        state_next = state;
        case (state)
            IDLE:    if (enable_i) state_next = PRIME;
            PRIME:   if (prime_pend) state_next = RUN;
            RUN:     if (wrap && ch == CH_RIGHT && !enable_i) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch         <= CH_LEFT;
            b          <= '0;
            shreg      <= '0;
            next_word  <= '0;
            sdata      <= 1'b0;
            underrun   <= 1'b0;
            prime_pend <= 1'b0;
            cap_pend   <= 1'b0;
            armed      <= 1'b0;
        end else begin
            cap_pend <= pf_rd;
            if (state == IDLE && enable_i) underrun <= 1'b0;
            if (prime_rd) prime_pend <= 1'b1;
            if (state == PRIME && prime_pend) begin
                prime_pend <= 1'b0;
                shreg      <= fifo_data_i;
                b          <= '0;
                ch         <= CH_LEFT;
                sdata      <= 1'b0;
                armed      <= 1'b0;
            end
            if (pf_miss) begin
                next_word <= '0;
                underrun  <= 1'b1;
            end
            if (cap_pend) next_word <= fifo_data_i;
            if (run_en && fall) begin
                if (at_last) begin
                    b     <= '0;
                    ch    <= other_channel(ch);
                    shreg <= next_word;
                    sdata <= 1'b0;
                    armed <= 1'b0;
                end else begin
                    b <= b + 1'b1;
                    // Bit 0 of each slot is the I2S delay bit; data follows, then padding.
                    if (b < DATA_B) begin
                        sdata <= shreg[DATA_WIDTH-1];
                        shreg <= shreg << 1;
                    end else begin
                        sdata <= 1'b0;
                    end
                    if (b == PF_B) begin
                        armed <= (ch == CH_LEFT) || enable_i;
                        if (ch == CH_RIGHT && !enable_i) next_word <= '0;
                    end
                end
            end
        end
    end

    assign fifo_rd_en_o = !rst && (prime_rd || pf_rd);
    assign bclk_o       = bclk;
    assign lrclk_o      = ch;
    assign sdata_o      = sdata;
    assign busy_o       = (state != IDLE);
    assign underrun_o   = underrun;

endmodule
